// File: rtl/simd_mul_wb.sv
// simd_mul_wb: buffers multiplier results and writes them to the VRF at consecutive word addresses
module simd_mul_wb #(
    parameter int Depth     = 2,
    parameter int AddrWidth = 10,
    parameter int LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic [63:0]          res_data_i,
    input  logic [7:0]           res_strb_i,
    output logic                 wb_req_o,
    input  logic                 wb_gnt_i,
    output logic [AddrWidth-1:0] wb_addr_o,
    output logic [63:0]          wb_data_o,
    output logic [7:0]           wb_be_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int PW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t               r_state;
    logic [63:0]          r_data [Depth];
    logic [7:0]           r_strb [Depth];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_cnt;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_acc, r_ret;
    logic                 w_run, w_full, w_push, w_req, w_pop;
    assign w_run       = r_state == S_RUN;
    assign w_full      = r_cnt == CW'(Depth);
    assign res_ready_o = w_run && r_acc != '0 && !w_full;
    assign w_push      = res_valid_i && res_ready_o;
    assign w_req       = w_run && r_cnt != '0 && r_strb[r_rptr] != 8'h00;
    assign w_pop       = w_run && r_cnt != '0 && (r_strb[r_rptr] == 8'h00 || wb_gnt_i);
    assign cmd_ready_o = r_state == S_IDLE;
    assign busy_o      = w_run;
    assign done_o      = r_state == S_DONE;
    assign wb_req_o    = w_req;
    assign wb_addr_o   = w_req ? r_addr : '0;
    assign wb_data_o   = w_req ? r_data[r_rptr] : '0;
    assign wb_be_o     = w_req ? r_strb[r_rptr] : '0;
    // result storage; contents only matter while counted as occupied
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wptr] <= res_data_i;
            r_strb[r_wptr] <= res_strb_i;
        end
    end
    // control FSM, FIFO pointers, address walk and word counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_acc   <= '0;
            r_ret   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr == PW'(Depth - 1) ? '0 : r_wptr + PW'(1);
                r_acc  <= r_acc - LenWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr == PW'(Depth - 1) ? '0 : r_rptr + PW'(1);
                r_ret  <= r_ret - LenWidth'(1);
                r_addr <= r_addr + AddrWidth'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    r_state <= S_RUN;
                    r_addr  <= cmd_addr_i;
                    r_acc   <= cmd_len_i;
                    r_ret   <= cmd_len_i;
                end
                S_RUN: if (r_ret == '0 || (w_pop && r_ret == LenWidth'(1))) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simd_mul_wb.sv
// tb_simd_mul_wb: directed vector table plus hand sequences for the VRF writeback stage
module tb_simd_mul_wb;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o;
    logic [9:0]  cmd_addr_i;
    logic [15:0] cmd_len_i;
    logic        res_valid_i, res_ready_o;
    logic [63:0] res_data_i;
    logic [7:0]  res_strb_i;
    logic        wb_req_o, wb_gnt_i;
    logic [9:0]  wb_addr_o;
    logic [63:0] wb_data_o;
    logic [7:0]  wb_be_o;
    logic        busy_o, done_o;
    int          checks = 0, failures = 0, done_cnt = 0;
    logic [81:0] wq [$];
    logic        p_req = 1'b0, p_gnt = 1'b0;
    logic [81:0] p_v = '0;

    simd_mul_wb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_data_i(res_data_i), .res_strb_i(res_strb_i),
        .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_be_o(wb_be_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic cv; logic [9:0] ca; logic [15:0] cl;
        logic rv; logic [63:0] rd; logic [7:0] rs; logic g;
        logic cr; logic rr; logic rq; logic [9:0] ad; logic [63:0] dt; logic [7:0] be; logic bz; logic dn;
    } vec_t;
    vec_t tv [15];

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({cmd_ready_o, res_ready_o, wb_req_o, wb_addr_o, wb_data_o, wb_be_o, busy_o, done_o});
    endfunction

    // sample just before each rising edge: log granted writes, count done pulses, check request hold
    always @(negedge clk_i) begin
        #4;
        if (rst_i) p_req = 1'b0;
        else begin
            if (p_req && !p_gnt) chk("hold", 128'({wb_req_o, wb_addr_o, wb_be_o, wb_data_o}), 128'({1'b1, p_v}));
            if (wb_req_o && wb_gnt_i) wq.push_back({wb_addr_o, wb_be_o, wb_data_o});
            if (done_o) done_cnt++;
            p_req = wb_req_o;
            p_gnt = wb_gnt_i;
            p_v   = {wb_addr_o, wb_be_o, wb_data_o};
        end
    end

    task automatic stream(input logic [9:0] base, input logic [15:0] len, input int nres, input int glow);
        int k = 0, c = 0, w0 = wq.size(), d0 = done_cnt;
        bit seen = 1'b0;
        logic [81:0] w;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = base; cmd_len_i = len;
        #1 chk("cmd_rdy", 128'(cmd_ready_o), 128'(1));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        while (!seen && c < 200) begin
            res_valid_i = k < nres;
            res_data_i  = {32'hA5A5A5A5, 6'd0, base, 16'(k)};
            res_strb_i  = 8'hFF;
            wb_gnt_i    = c >= glow;
            #1;
            if (glow > 0 && c < glow && k == 2) chk("bp_full", 128'(res_ready_o), 128'(0));
            if (glow > 0 && c >= 1 && c < glow)
                chk("bp_hold", 128'({wb_req_o, wb_addr_o, wb_data_o, wb_be_o}),
                    128'({1'b1, base, 32'hA5A5A5A5, 6'd0, base, 16'd0, 8'hFF}));
            seen = done_o;
            #3;
            if (res_valid_i && res_ready_o) k++;
            @(negedge clk_i);
            c++;
        end
        #1;
        chk("timeout", 128'(seen), 128'(1));
        chk("after_idle", 128'({cmd_ready_o, res_ready_o}), 128'(2'b10));
        chk("accepted", 128'(k), 128'(len));
        chk("nwrites", 128'(wq.size() - w0), 128'(len));
        chk("ndone", 128'(done_cnt - d0), 128'(1));
        for (int i = 0; i < int'(len); i++) begin
            w = (w0 + i < wq.size()) ? wq[w0 + i] : '0;
            chk($sformatf("write%0d", i), 128'(w), 128'({base + 10'(i), 8'hFF, 32'hA5A5A5A5, 6'd0, base, 16'(i)}));
        end
        res_valid_i = 1'b0;
        wb_gnt_i    = 1'b1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        logic [81:0] w;
        tv[0]  = '{1'b1, 10'h010, 16'd4, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 10'h000, 16'd0, 1'b1, 64'd1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 64'd0, 8'h00, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 10'h000, 16'd0, 1'b1, 64'd2, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'h010, 64'd1, 8'hFF, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 10'h000, 16'd0, 1'b1, 64'd3, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'h011, 64'd2, 8'hFF, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 10'h000, 16'd0, 1'b1, 64'd4, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'h012, 64'd3, 8'hFF, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h013, 64'd4, 8'hFF, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 10'h020, 16'd3, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 10'h000, 16'd0, 1'b1, 64'hA, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 64'd0, 8'h00, 1'b1, 1'b0};
        tv[10] = '{1'b0, 10'h000, 16'd0, 1'b1, 64'hB, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020, 64'hA, 8'h0F, 1'b1, 1'b0};
        tv[11] = '{1'b0, 10'h000, 16'd0, 1'b1, 64'hC, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 64'd0, 8'h00, 1'b1, 1'b0};
        tv[12] = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h022, 64'hC, 8'hF0, 1'b1, 1'b0};
        tv[13] = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b1};
        tv[14] = '{1'b0, 10'h000, 16'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 64'd0, 8'h00, 1'b0, 1'b0};
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        res_valid_i = 1'b0; res_data_i = '0; res_strb_i = '0; wb_gnt_i = 1'b0;
        #1 chk("reset", outs(), 128'({1'b1, 1'b0, 1'b0, 10'h0, 64'h0, 8'h0, 1'b0, 1'b0}));
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            cmd_valid_i = tv[i].cv; cmd_addr_i = tv[i].ca; cmd_len_i = tv[i].cl;
            res_valid_i = tv[i].rv; res_data_i = tv[i].rd; res_strb_i = tv[i].rs; wb_gnt_i = tv[i].g;
            #1 chk($sformatf("vec%0d", i), outs(),
                   128'({tv[i].cr, tv[i].rr, tv[i].rq, tv[i].ad, tv[i].dt, tv[i].be, tv[i].bz, tv[i].dn}));
        end
        chk("tbl_done", 128'(done_cnt), 128'(2));
        stream(10'h100, 16'd6, 6, 5);
        stream(10'h3FF, 16'd2, 2, 0);
        w = wq[wq.size() - 1];
        chk("wrap_last", 128'(w[81:72]), 128'(10'h000));
        w0 = wq.size(); d0 = done_cnt;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = 10'h123; cmd_len_i = 16'd0;
        #1 chk("zl_cmd", 128'(cmd_ready_o), 128'(1));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        #1 chk("zl_run", 128'({busy_o, done_o, wb_req_o, res_ready_o}), 128'(4'b1000));
        @(negedge clk_i);
        #1 chk("zl_done", 128'({done_o, wb_req_o}), 128'(2'b10));
        @(negedge clk_i);
        #1 chk("zl_idle", 128'(cmd_ready_o), 128'(1));
        chk("zl_nowrite", 128'(wq.size() - w0), 128'(0));
        chk("zl_ndone", 128'(done_cnt - d0), 128'(1));
        stream(10'h200, 16'd2, 4, 0);
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = 10'h050; cmd_len_i = 16'd2;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; res_valid_i = 1'b1; res_data_i = 64'h5555; res_strb_i = 8'hFF; wb_gnt_i = 1'b0;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        #1 chk("pre_rst_req", 128'({wb_req_o, wb_addr_o}), 128'({1'b1, 10'h050}));
        d0 = done_cnt;
        #1 rst_i = 1'b1;
        #1 chk("rst_async", outs(), 128'({1'b1, 1'b0, 1'b0, 10'h0, 64'h0, 8'h0, 1'b0, 1'b0}));
        @(negedge clk_i);
        rst_i = 1'b0;
        wb_gnt_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_nodone", 128'(done_cnt - d0), 128'(0));
        stream(10'h060, 16'd1, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simd_mul_wb.md
# simd_mul_wb

Writeback stage directly downstream of the lane SIMD multiplier. It consumes 64-bit results and their byte strobes over a valid/ready handshake and buffers them in a small FIFO. It then issues one VRF write request per result, walking a linear word address from a command-supplied base. It signals completion once the commanded number of words has been retired.

## Interface

Parameters:
- `Depth`, default 2: result FIFO entries. Must be ≥1. A value of 2 or more is required for 1 word/cycle throughput.
- `AddrWidth`, default 10: VRF word-address width.
- `LenWidth`, default 16: width of the word-count field.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: asynchronous active-high reset.
- `cmd_valid_i`, input, 1: command offered.
- `cmd_ready_o`, output, 1: command accepted. High only in IDLE.
- `cmd_addr_i`, input, AddrWidth: base word address.
- `cmd_len_i`, input, LenWidth: number of result words to retire.
- `res_valid_i`, input, 1: multiplier result valid.
- `res_ready_o`, output, 1: result accepted.
- `res_data_i`, input, 64: multiplier result word.
- `res_strb_i`, input, 8: multiplier byte mask for the word.
- `wb_req_o`, output, 1: VRF write request.
- `wb_gnt_i`, input, 1: VRF grant. The write completes in the cycle where `wb_req_o` and `wb_gnt_i` are both high.
- `wb_addr_o`, output, AddrWidth: write word address.
- `wb_data_o`, output, 64: write data.
- `wb_be_o`, output, 8: byte enables.
- `busy_o`, output, 1: high in RUN.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation

States:
- IDLE: `cmd_ready_o` is 1. A command handshake latches `cmd_addr_i` into the address register and `cmd_len_i` into two counters, `acc_cnt` and `ret_cnt`. Next state is RUN.
- RUN:
  - `res_ready_o = (acc_cnt != 0) && !fifo_full`. It must not depend on `wb_gnt_i`.
  - Each result handshake pushes {data, strb} into the FIFO and decrements `acc_cnt`.
- Retiring the FIFO head:
  - Head strb ≠ 0: drive `wb_req_o=1` with the head data/strb and the current address. On grant, pop the head, increment the address and decrement `ret_cnt`.
  - Head strb == 0: pop the head in one cycle with no request (`wb_req_o` stays 0). Still increment the address and decrement `ret_cnt`.
- Completion: when `ret_cnt` reaches 0, go to DONE.
- DONE: `done_o=1` for exactly one cycle, then IDLE.
- `cmd_len_i == 0`: IDLE → RUN → DONE with no result accepted and no request issued.
- Address arithmetic is modulo 2^AddrWidth. Base all-ones followed by the next word wraps to 0.
- Results offered while in IDLE or DONE, or after `acc_cnt` reaches 0, are never accepted (`res_ready_o=0`).
- Once `wb_req_o` is asserted, the request, address, data and byte enables are held stable until granted. A request is never retracted.

## Timing

Reset values (asynchronous on `rst_i`):
- State IDLE, FIFO empty, counters 0.
- `cmd_ready_o=1`. `res_ready_o`, `wb_req_o`, `busy_o` and `done_o` are 0.
- `wb_addr_o`, `wb_data_o` and `wb_be_o` are 0.

Cycle behaviour:
- FIFO is registered, not fall-through. A result accepted in cycle t can drive `wb_req_o` no earlier than t+1.
- Full FIFO with a simultaneous pop: `res_ready_o` stays 0 that cycle. The freed slot is visible in t+1.
- With `Depth` ≥ 2, grant held high and results valid every cycle, the block sustains 1 word/cycle after the first-word latency of 1 cycle.
- `done_o` asserts in the cycle after the final retirement (grant, or zero-strb pop). `cmd_ready_o` rises one cycle after `done_o`.

Reset:
- A reset asserted mid-command flushes the FIFO and returns to IDLE immediately.
- No `done_o` is produced for the aborted command.

## Test plan

- Basic run: command addr=0x010, len=4. Four results with strb=0xFF and data 1..4, grant always high. Required: writes to 0x010..0x013 with data 1..4, `done_o` pulse once, then `cmd_ready_o`=1.
- Backpressure, `Depth`=2: grant low for 5 cycles during a len=6 stream. Required:
  - `res_ready_o` drops after 2 words are buffered.
  - `wb_req_o`, `wb_addr_o`, `wb_data_o` and `wb_be_o` are held stable throughout.
  - No word is lost or duplicated once grant returns.
- Masked words: len=3 with strb 0x0F, 0x00, 0xF0 at base 0x020. Required:
  - Write to 0x020 with `wb_be_o`=0x0F.
  - No request for the second word.
  - Write to 0x022 with `wb_be_o`=0xF0.
  - `done_o` asserts.
- Wrap and zero length: base 0x3FF (`AddrWidth`=10), len=2. Required: writes to 0x3FF then 0x000. Then a command with len=0 produces `done_o` two cycles after the handshake with no `wb_req_o`.
- Extra results: len=2 with `res_valid_i` held high for 4 words. Required: exactly 2 are accepted, and `res_ready_o`=0 afterwards.
- Mid-op reset: assert `rst_i` with 1 word buffered and a request pending. Required:
  - All outputs take their reset values asynchronously, in the same cycle.
  - No `done_o`.
  - A following len=1 command writes correctly.
